// File: rtl/osd_stream_arbiter.sv
// osd_stream_arbiter
// Two-source Avalon-ST video arbiter feeding one OSD video path. A source owns
// the output for a whole frame: any control/user packets plus the closing
// video-data packet. Ownership changes only on a frame boundary. While idle,
// stray mid-packet beats are consumed and flagged. Completed frames are
// counted per source.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no owner; arbitrate SOP requests, swallow stray non-SOP beats
// GRANT0 | port 0 owns dout until an accepted video-packet EOP
// GRANT1 | port 1 owns dout until an accepted video-packet EOP
module osd_stream_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter bit RR_EN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] din0_data,
  input  logic                  din0_valid,
  input  logic                  din0_startofpacket,
  input  logic                  din0_endofpacket,
  output logic                  din0_ready,

  input  logic [DATA_WIDTH-1:0] din1_data,
  input  logic                  din1_valid,
  input  logic                  din1_startofpacket,
  input  logic                  din1_endofpacket,
  output logic                  din1_ready,

  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  input  logic                  dout_ready,

  output logic [1:0]            grant,
  output logic [15:0]           frame_cnt0,
  output logic [15:0]           frame_cnt1,
  output logic                  drop_flag
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT0 = 2'd1,
    S_GRANT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // last_grant holds the port index of the most recent grant; it resets to 1
  // so that port 0 wins the first contention under round-robin.
  logic last_grant;
  logic last_grant_nxt;

  // Type of the packet currently passing through (1 = video data).
  logic is_video;

  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;
  logic        drop_q;

  logic req0;
  logic req1;

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_sop;
  logic                  sel_eop;
  logic                  in_grant;
  logic                  accept;
  logic                  sop_is_video;
  logic                  frame_end;
  logic                  stray0;
  logic                  stray1;

  assign req0   = din0_valid & din0_startofpacket;
  assign req1   = din1_valid & din1_startofpacket;
  assign stray0 = din0_valid & ~din0_startofpacket;
  assign stray1 = din1_valid & ~din1_startofpacket;

  // Select the owning source's stream for type tracking and frame-end detection.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    in_grant  = 1'b0;
    case (state)
      S_GRANT0: begin
        sel_data  = din0_data;
        sel_valid = din0_valid;
        sel_sop   = din0_startofpacket;
        sel_eop   = din0_endofpacket;
        in_grant  = 1'b1;
      end
      S_GRANT1: begin
        sel_data  = din1_data;
        sel_valid = din1_valid;
        sel_sop   = din1_startofpacket;
        sel_eop   = din1_endofpacket;
        in_grant  = 1'b1;
      end
      default: begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        in_grant  = 1'b0;
      end
    endcase
  end

  // A single-beat packet (SOP and EOP together) is judged by its own type,
  // since the latched flag still describes the previous packet.
  assign accept       = in_grant & sel_valid & dout_ready;
  assign sop_is_video = (sel_data[3:0] == 4'h0);
  assign frame_end    = accept & sel_eop & (sel_sop ? sop_is_video : is_video);

  // Next-state logic: arbitrate in IDLE, release only on a video frame end.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      S_IDLE: begin
        if (req0 && req1) begin
          if (RR_EN && (last_grant == 1'b0)) begin
            state_nxt      = S_GRANT1;
            last_grant_nxt = 1'b1;
          end else begin
            state_nxt      = S_GRANT0;
            last_grant_nxt = 1'b0;
          end
        end else if (req0) begin
          state_nxt      = S_GRANT0;
          last_grant_nxt = 1'b0;
        end else if (req1) begin
          state_nxt      = S_GRANT1;
          last_grant_nxt = 1'b1;
        end
      end
      S_GRANT0: begin
        if (frame_end) state_nxt = S_IDLE;
      end
      S_GRANT1: begin
        if (frame_end) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs: zero-latency pass-through of the owner, resync readiness in IDLE.
  always_comb begin
    dout_data          = '0;
    dout_valid         = 1'b0;
    dout_startofpacket = 1'b0;
    dout_endofpacket   = 1'b0;
    din0_ready         = 1'b0;
    din1_ready         = 1'b0;
    grant              = 2'b00;
    case (state)
      S_IDLE: begin
        din0_ready = stray0;
        din1_ready = stray1;
      end
      S_GRANT0: begin
        dout_data          = din0_data;
        dout_valid         = din0_valid;
        dout_startofpacket = din0_startofpacket;
        dout_endofpacket   = din0_endofpacket;
        din0_ready         = dout_ready;
        grant              = 2'b01;
      end
      S_GRANT1: begin
        dout_data          = din1_data;
        dout_valid         = din1_valid;
        dout_startofpacket = din1_startofpacket;
        dout_endofpacket   = din1_endofpacket;
        din1_ready         = dout_ready;
        grant              = 2'b10;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

  // State register and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Latch packet type on every accepted SOP; a new SOP simply restarts tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_video <= 1'b0;
    end else if (accept && sel_sop) begin
      is_video <= sop_is_video;
    end
  end

  // Per-source completed-frame counters, free-running wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (frame_end) begin
      if (state == S_GRANT0) cnt0_q <= cnt0_q + 16'd1;
      if (state == S_GRANT1) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  // Sticky flag: any non-SOP beat swallowed while no source owns the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= 1'b0;
    end else if ((state == S_IDLE) && (stray0 || stray1)) begin
      drop_q <= 1'b1;
    end
  end

  assign frame_cnt0 = cnt0_q;
  assign frame_cnt1 = cnt1_q;
  assign drop_flag  = drop_q;

endmodule
